color_centroid_tracker: RTL and testbench
=========================================

// Module: color_centroid_tracker
// PURPOSE
// - Sits directly downstream of pixel_cost_function. Consumes per-pixel red/green/blue costs (9b each) plus pixel coordinates.
// - Accumulates cost-weighted x/y sums and total cost per colour over one camera frame.
// - At end of frame, computes each colour's centroid with one shared serial divider, for the laser steering logic.
// PARAMETERS
// - X_W      10   pixel_x / pixel_y / centroid width (covers 640x480)
// - COST_W    9   cost input width
// - SUMW_W   28   total-cost accumulator width (19b pixel count + COST_W)
// - SUMC_W   38   weighted-coordinate accumulator width (SUMW_W + X_W)
// - MIN_WEIGHT 64 minimum total cost for a colour to count as found
// PORTS
// - clk               in   1     system clock
// - reset             in   1     asynchronous, active-high reset
// - pixel_valid       in   1     qualifies pixel_x/y and the three costs this cycle
// - pixel_x           in   X_W   column of current pixel
// - pixel_y           in   X_W   row of current pixel (zero-extended)
// - pixel_red_cost    in   COST_W  from pixel_cost_function
// - pixel_green_cost  in   COST_W
// - pixel_blue_cost   in   COST_W
// - frame_done        in   1     1-cycle pulse: last pixel of frame has been presented
// - red_x, red_y      out  X_W   red centroid
// - green_x, green_y  out  X_W   green centroid
// - blue_x, blue_y    out  X_W   blue centroid
// - found             out  3     {red,green,blue}: colour total cost >= MIN_WEIGHT
// - result_valid      out  1     1-cycle pulse: new centroids/found are on outputs
// - busy              out  1     division sequence in progress
// - overrun           out  1     1-cycle pulse: frame_done arrived while busy
// BEHAVIOUR
// Reset
// - All outputs 0. Accumulators and snapshots 0. FSM in IDLE.
// - Reset mid-sequence aborts the sequence. No result_valid is issued.
// Accumulation (every cycle)
// - Per colour c, on each pixel_valid: W_c += cost, SX_c += cost*pixel_x, SY_c += cost*pixel_y.
// - Accumulators wrap and do not saturate; the widths above cover a full 640x480 frame at max cost.
// Frame end
// - At the edge where frame_done=1 and FSM=IDLE: copy W/SX/SY (including this cycle's pixel when pixel_valid=1) into snapshot registers.
// - In the same cycle, clear the accumulators. A pixel that is valid on this cycle is not carried into the next frame.
// - FSM then goes to DIV.
// - frame_done while busy: overrun pulses the next cycle and the accumulators clear (that frame is discarded). The running sequence is unaffected.
// FSM
// - IDLE -> DIV -> DONE -> IDLE.
// - DIV issues 6 divisions in order: rx, ry, gx, gy, bx, by. Each is SX_c/W_c or SY_c/W_c.
// - Each division takes X_W+2 cycles: 1 load, X_W iterate, 1 capture.
// - DONE (1 cycle): drives result_valid=1. busy=1 in DIV, 0 in IDLE and DONE.
// Latency
// - frame_done sampled at edge N gives result_valid high in the cycle after edge N+6*(X_W+2)+1 (N+73 for X_W=10).
// Results
// - Captured quotient goes to a staging register. All outputs update together when result_valid goes high, and hold until the next result_valid.
// - W_c < MIN_WEIGHT (includes W_c=0): found[c]=0, that colour's x and y = 0. Timing is unchanged: the division still runs and its result is discarded.
// - A quotient >= 2^X_W saturates to all-ones. This is unreachable for in-range coordinates.
// Divider
// - Restoring, unsigned, 1 quotient bit/cycle.
// - The dividend is pre-shifted so only X_W iterations are needed.
// - Truncating, no rounding.
// STRUCTURE
// - Package centroid_pkg: X_W, COST_W, SUMW_W, SUMC_W; FSM state enum {IDLE,DIV,DONE}; division index constants 0..5.
// - Sub-module serial_divider (ports: clk, reset, start, dividend[SUMC_W], divisor[SUMW_W], quotient[X_W], done).
// - Top level holds the accumulators, the snapshots, the FSM/index counter, and the output registers.
// TESTING
// - Reset: assert reset mid-DIV. All outputs go 0 immediately, busy=0, and no result_valid follows.
// - Single red pixel (100,50), red cost 100, then frame_done: after 73 cycles red=(100,50), found=3'b100, green/blue=(0,0).
// - Two red pixels: (100,50) cost 10 and (200,150) cost 30 (MIN_WEIGHT=32). Result red=(175,125), found[2]=1.
// - Empty frame (no pixel_valid), then frame_done: result_valid after 73 cycles, found=000, all coordinates 0.
// - pixel_valid and frame_done in the same cycle at (300,200), blue cost 80: the pixel is included, blue=(300,200), and the next frame's W_blue starts at 0.
// - frame_done again 10 cycles after the first: overrun pulses once, first result is delivered intact, and the second frame's data is discarded.

Source files
------------

// File: rtl/centroid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : centroid_pkg
// Description : Shared widths, FSM state type and division-slot constants
//               for the colour centroid tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package centroid_pkg;

  localparam int X_W        = 10;               // coordinate / centroid width
  localparam int COST_W     = 9;                // per-pixel cost width
  localparam int SUMW_W     = 28;               // total-cost accumulator width
  localparam int SUMC_W     = 38;               // weighted-coordinate accumulator width
  localparam int PROD_W     = X_W + COST_W;     // cost * coordinate product width
  localparam int NUM_COLORS = 3;                // red, green, blue
  localparam int NUM_DIVS   = 6;                // x and y per colour
  localparam int IDX_W      = 3;                // division slot index width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Division slots, issued in this order; bit 0 selects y, bits [2:1] the colour.
  localparam logic [IDX_W-1:0] DIV_RX = 3'd0;
  localparam logic [IDX_W-1:0] DIV_RY = 3'd1;
  localparam logic [IDX_W-1:0] DIV_GX = 3'd2;
  localparam logic [IDX_W-1:0] DIV_GY = 3'd3;
  localparam logic [IDX_W-1:0] DIV_BX = 3'd4;
  localparam logic [IDX_W-1:0] DIV_BY = 3'd5;

  // Colour (0=red, 1=green, 2=blue) that a division slot belongs to.
  function automatic logic [1:0] div_color(input logic [IDX_W-1:0] idx);
    return idx[2:1];
  endfunction

  // True when a division slot computes the y coordinate.
  function automatic logic div_is_y(input logic [IDX_W-1:0] idx);
    return idx[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_divider.sv
`default_nettype none
// ============================================================================
// Module      : serial_divider
// Description : Restoring unsigned divider, one quotient bit per cycle.
//               The upper dividend bits seed the partial remainder so only
//               X_W iterations are needed; quotients that do not fit X_W bits
//               saturate to all-ones. Truncating.
//               Timing: load on start, X_W iterate cycles, 1 capture cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_divider
  import centroid_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SUMC_W-1:0] dividend,
  input  logic [SUMW_W-1:0] divisor,
  output logic [X_W-1:0]    quotient,
  output logic              done
);

  localparam int CNT_W = $clog2(X_W + 1);

  logic [SUMW_W-1:0] rem;       // partial remainder
  logic [SUMW_W-1:0] dvsr;      // latched divisor
  logic [X_W-1:0]    low_bits;  // dividend bits still to be shifted in
  logic [X_W-1:0]    q_acc;     // quotient under construction
  logic              sat;       // quotient cannot fit X_W bits
  logic              active;
  logic [CNT_W-1:0]  cnt;

  logic [SUMW_W:0]   trial;
  logic [SUMW_W:0]   diff;
  logic              fits;

  // One restoring step: shift next dividend bit in, subtract if it fits
  always_comb begin
    trial = {rem, low_bits[X_W-1]};
    diff  = trial - {1'b0, dvsr};
    fits  = (trial >= {1'b0, dvsr});
  end

  // Load / iterate / capture sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      dvsr     <= '0;
      low_bits <= '0;
      q_acc    <= '0;
      sat      <= 1'b0;
      active   <= 1'b0;
      cnt      <= '0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= dividend[SUMC_W-1:X_W];
        low_bits <= dividend[X_W-1:0];
        dvsr     <= divisor;
        // Upper part already >= divisor means quotient >= 2^X_W (also divisor 0)
        sat      <= (dividend[SUMC_W-1:X_W] >= divisor);
        q_acc    <= '0;
        cnt      <= CNT_W'(X_W);
        active   <= 1'b1;
      end else if (active) begin
        if (cnt != '0) begin
          rem      <= fits ? diff[SUMW_W-1:0] : trial[SUMW_W-1:0];
          low_bits <= {low_bits[X_W-2:0], 1'b0};
          q_acc    <= {q_acc[X_W-2:0], fits};
          cnt      <= cnt - 1'b1;
        end else begin
          quotient <= sat ? '1 : q_acc;
          done     <= 1'b1;
          active   <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/color_centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module      : color_centroid_tracker
// Description : Accumulates cost-weighted x/y sums and total cost for red,
//               green and blue over a frame, then computes each colour's
//               centroid with one shared serial divider at frame end.
// Revision    : 1.0 - initial release
// ============================================================================
module color_centroid_tracker
  import centroid_pkg::*;
#(
  parameter int MIN_WEIGHT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_valid,
  input  logic [X_W-1:0]    pixel_x,
  input  logic [X_W-1:0]    pixel_y,
  input  logic [COST_W-1:0] pixel_red_cost,
  input  logic [COST_W-1:0] pixel_green_cost,
  input  logic [COST_W-1:0] pixel_blue_cost,
  input  logic              frame_done,
  output logic [X_W-1:0]    red_x,
  output logic [X_W-1:0]    red_y,
  output logic [X_W-1:0]    green_x,
  output logic [X_W-1:0]    green_y,
  output logic [X_W-1:0]    blue_x,
  output logic [X_W-1:0]    blue_y,
  output logic [2:0]        found,
  output logic              result_valid,
  output logic              busy,
  output logic              overrun
);

  logic [COST_W-1:0] cost    [NUM_COLORS];
  logic [PROD_W-1:0] prod_x  [NUM_COLORS];
  logic [PROD_W-1:0] prod_y  [NUM_COLORS];
  logic [SUMW_W-1:0] acc_w   [NUM_COLORS];
  logic [SUMC_W-1:0] acc_sx  [NUM_COLORS];
  logic [SUMC_W-1:0] acc_sy  [NUM_COLORS];
  logic [SUMW_W-1:0] next_w  [NUM_COLORS];
  logic [SUMC_W-1:0] next_sx [NUM_COLORS];
  logic [SUMC_W-1:0] next_sy [NUM_COLORS];
  logic [SUMW_W-1:0] snap_w  [NUM_COLORS];
  logic [SUMC_W-1:0] snap_sx [NUM_COLORS];
  logic [SUMC_W-1:0] snap_sy [NUM_COLORS];
  logic [2:0]        found_c;             // indexed by colour (0=red)

  state_t            state;
  state_t            state_next;
  logic              launch;              // first DIV cycle: start slot 0
  logic [IDX_W-1:0]  idx;                 // slot currently in the divider
  logic [IDX_W-1:0]  sel_idx;             // slot whose operands feed the divider
  logic [X_W-1:0]    stage [NUM_DIVS];
  logic              frame_start;
  logic              frame_drop;

  logic              div_start;
  logic              div_done;
  logic [SUMC_W-1:0] div_dividend;
  logic [SUMW_W-1:0] div_divisor;
  logic [X_W-1:0]    div_quotient;
  logic [X_W-1:0]    q_masked;

  assign cost[0] = pixel_red_cost;
  assign cost[1] = pixel_green_cost;
  assign cost[2] = pixel_blue_cost;

  // A frame is snapshotted only when idle; otherwise a sequence still owns
  // the snapshots, so the new frame is thrown away.
  assign frame_start = frame_done && (state == IDLE);
  assign frame_drop  = frame_done && (state != IDLE);

  for (genvar c = 0; c < NUM_COLORS; c++) begin : g_color
    assign prod_x[c]  = PROD_W'(cost[c]) * PROD_W'(pixel_x);
    assign prod_y[c]  = PROD_W'(cost[c]) * PROD_W'(pixel_y);
    assign next_w[c]  = acc_w[c]  + (pixel_valid ? SUMW_W'(cost[c])   : '0);
    assign next_sx[c] = acc_sx[c] + (pixel_valid ? SUMC_W'(prod_x[c]) : '0);
    assign next_sy[c] = acc_sy[c] + (pixel_valid ? SUMC_W'(prod_y[c]) : '0);
    assign found_c[c] = (snap_w[c] >= SUMW_W'(MIN_WEIGHT));
  end

  // Running sums; frame_done snapshots (when idle) and always clears them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_COLORS; c++) begin
        acc_w[c]   <= '0;
        acc_sx[c]  <= '0;
        acc_sy[c]  <= '0;
        snap_w[c]  <= '0;
        snap_sx[c] <= '0;
        snap_sy[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_COLORS; c++) begin
        if (frame_done) begin
          acc_w[c]  <= '0;
          acc_sx[c] <= '0;
          acc_sy[c] <= '0;
          if (frame_start) begin
            snap_w[c]  <= next_w[c];
            snap_sx[c] <= next_sx[c];
            snap_sy[c] <= next_sy[c];
          end
        end else begin
          acc_w[c]  <= next_w[c];
          acc_sx[c] <= next_sx[c];
          acc_sy[c] <= next_sy[c];
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state, status outputs and divider launch
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    div_start    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_next = DIV;
      end
      DIV: begin
        busy      = 1'b1;
        div_start = launch || (div_done && (idx != DIV_BY));
        if (div_done && (idx == DIV_BY)) state_next = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Divider operand selection: back-to-back launch uses the following slot
  always_comb begin
    sel_idx      = (launch || (idx == DIV_BY)) ? idx : idx + 3'd1;
    div_dividend = div_is_y(sel_idx) ? snap_sy[div_color(sel_idx)]
                                     : snap_sx[div_color(sel_idx)];
    div_divisor  = snap_w[div_color(sel_idx)];
    q_masked     = found_c[div_color(idx)] ? div_quotient : '0;
  end

  // Division slot counter and quotient staging
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      launch <= 1'b0;
      idx    <= DIV_RX;
      for (int i = 0; i < NUM_DIVS; i++) stage[i] <= '0;
    end else begin
      launch <= frame_start;
      if (frame_start) begin
        idx <= DIV_RX;
      end else if ((state == DIV) && div_done && (idx != DIV_BY)) begin
        idx <= idx + 3'd1;
      end
      if ((state == DIV) && div_done) stage[idx] <= q_masked;
    end
  end

  // Result registers, updated together as the sequence finishes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_x   <= '0;
      red_y   <= '0;
      green_x <= '0;
      green_y <= '0;
      blue_x  <= '0;
      blue_y  <= '0;
      found   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= frame_drop;
      if ((state == DIV) && div_done && (idx == DIV_BY)) begin
        red_x   <= stage[DIV_RX];
        red_y   <= stage[DIV_RY];
        green_x <= stage[DIV_GX];
        green_y <= stage[DIV_GY];
        blue_x  <= stage[DIV_BX];
        blue_y  <= q_masked;
        found   <= {found_c[0], found_c[1], found_c[2]};
      end
    end
  end

  serial_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .done     (div_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_color_centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_centroid_tracker
// Description : Self-checking bench for color_centroid_tracker with a
//               frame-level reference model (plain sums and division).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_centroid_tracker;

  localparam int MINW = 32;
  localparam int LAT  = 73;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_valid = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [8:0] rc = '0;
  logic [8:0] gc = '0;
  logic [8:0] bc = '0;
  logic       frame_done = 1'b0;
  logic [9:0] red_x, red_y, green_x, green_y, blue_x, blue_y;
  logic [2:0] found;
  logic       result_valid, busy, overrun;

  color_centroid_tracker #(.MIN_WEIGHT(MINW)) dut (
    .clk              (clk),
    .reset            (reset),
    .pixel_valid      (pixel_valid),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .pixel_red_cost   (rc),
    .pixel_green_cost (gc),
    .pixel_blue_cost  (bc),
    .frame_done       (frame_done),
    .red_x            (red_x),
    .red_y            (red_y),
    .green_x          (green_x),
    .green_y          (green_y),
    .blue_x           (blue_x),
    .blue_y           (blue_y),
    .found            (found),
    .result_valid     (result_valid),
    .busy             (busy),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  int     n_assert = 0;
  int     n_fail   = 0;
  int     fd_edge  = 0;
  longint mw [3];
  longint msx[3];
  longint msy[3];
  longint ex_x[3];
  longint ex_y[3];
  logic [2:0] ex_found;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      mw[c] = 0; msx[c] = 0; msy[c] = 0;
    end
  endtask

  // Centroid of each colour from the frame sums
  task automatic model_close();
    ex_found = 3'b000;
    for (int c = 0; c < 3; c++) begin
      if (mw[c] >= MINW) begin
        ex_x[c] = msx[c] / mw[c];
        ex_y[c] = msy[c] / mw[c];
        if (ex_x[c] > 1023) ex_x[c] = 1023;
        if (ex_y[c] > 1023) ex_y[c] = 1023;
        ex_found[2-c] = 1'b1;
      end else begin
        ex_x[c] = 0;
        ex_y[c] = 0;
      end
    end
  endtask

  // One input cycle; drop=1 marks a frame_done expected to be discarded
  task automatic drive(input int pv, input int x, input int y, input int r,
                       input int g, input int b, input int fd, input int drop);
    @(negedge clk);
    pixel_valid = (pv != 0);
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    rc          = 9'(r);
    gc          = 9'(g);
    bc          = 9'(b);
    frame_done  = (fd != 0);
    if (pv != 0) begin
      mw[0] += r; msx[0] += longint'(r) * x; msy[0] += longint'(r) * y;
      mw[1] += g; msx[1] += longint'(g) * x; msy[1] += longint'(g) * y;
      mw[2] += b; msx[2] += longint'(b) * x; msy[2] += longint'(b) * y;
    end
    if (fd != 0) begin
      if (drop == 0) begin
        model_close();
        fd_edge = edge_cnt + 1;
      end
      model_clear();
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_found"}, found, ex_found);
    chk({tag, "_rx"}, red_x, ex_x[0]);
    chk({tag, "_ry"}, red_y, ex_y[0]);
    chk({tag, "_gx"}, green_x, ex_x[1]);
    chk({tag, "_gy"}, green_y, ex_y[1]);
    chk({tag, "_bx"}, blue_x, ex_x[2]);
    chk({tag, "_by"}, blue_y, ex_y[2]);
  endtask

  // Waits (bounded) for result_valid, then checks latency, values and hold
  task automatic wait_result(input string tag);
    int n = 0;
    bit got = 1'b0;
    while (n < 200 && !got) begin
      @(negedge clk);
      pixel_valid = 1'b0;
      frame_done  = 1'b0;
      n++;
      if (n == 1) chk({tag, "_busy"}, busy, 1);
      got = (result_valid === 1'b1);
    end
    chk({tag, "_latency"}, edge_cnt - fd_edge, LAT);
    chk({tag, "_busy_done"}, busy, 0);
    check_outputs(tag);
    @(negedge clk);
    chk({tag, "_rv_pulse"}, result_valid, 0);
    chk({tag, "_hold_rx"}, red_x, ex_x[0]);
    chk({tag, "_hold_by"}, blue_y, ex_y[2]);
  endtask

  function automatic int rand_cost();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(0, 7));
      default: return int'($urandom_range(0, 511));
    endcase
  endfunction

  initial begin
    int rv_seen;
    model_clear();
    for (int c = 0; c < 3; c++) begin ex_x[c] = 0; ex_y[c] = 0; end
    ex_found = 3'b000;

    // Reset state
    @(negedge clk);
    chk("reset_rv", result_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single red pixel
    drive(1, 100, 50, 100, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    wait_result("single");
    chk("single_red_x_const", red_x, 100);
    chk("single_red_y_const", red_y, 50);

    // Two red pixels, weighted mean
    drive(1, 100, 50, 10, 0, 0, 0, 0);
    drive(1, 200, 150, 30, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    wait_result("two");
    chk("two_red_x_const", red_x, 175);
    chk("two_red_y_const", red_y, 125);

    // Empty frame
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    wait_result("empty");

    // Pixel on the frame_done cycle is included, next frame starts clean
    drive(1, 300, 200, 0, 0, 80, 1, 0);
    wait_result("same_cycle");
    chk("same_cycle_bx_const", blue_x, 300);
    drive(1, 10, 10, 0, 0, 40, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    wait_result("next_frame");
    chk("next_frame_bx_const", blue_x, 10);

    // MIN_WEIGHT boundary and maximum cost corners
    drive(1, 5, 5, MINW - 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    wait_result("below_min");
    drive(1, 5, 5, MINW, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    wait_result("at_min");
    drive(1, 639, 479, 511, 511, 511, 0, 0);
    drive(1, 0, 0, 0, 511, 0, 0, 0);
    drive(1, 639, 0, 0, 0, 511, 1, 0);
    wait_result("max_cost");

    // Overrun: second frame_done 10 cycles after the first
    drive(1, 400, 300, 50, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) drive(1, 20, 20, 0, 200, 0, 0, 0);
    drive(1, 30, 30, 0, 200, 0, 1, 1);
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_done  = 1'b0;
    chk("overrun_pulse", overrun, 1);
    @(negedge clk);
    chk("overrun_single", overrun, 0);
    wait_result("overrun_first");
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    wait_result("overrun_discard");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      int np;
      np = int'($urandom_range(0, 20));
      for (int p = 0; p < np; p++) begin
        drive(1, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
              rand_cost(), rand_cost(), rand_cost(), 0, 0);
        if ($urandom_range(0, 3) == 0) drive(0, 0, 0, 0, 0, 0, 0, 0);
      end
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 639)),
            int'($urandom_range(0, 479)), rand_cost(), rand_cost(), rand_cost(), 1, 0);
      wait_result($sformatf("rand%0d", f));
    end

    // Reset in the middle of a division sequence
    drive(1, 321, 123, 100, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    wait_result("pre_reset");
    drive(1, 50, 60, 100, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (20) @(negedge clk);
    frame_done  = 1'b0;
    pixel_valid = 1'b0;
    chk("mid_div_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("reset_async_busy", busy, 0);
    chk("reset_async_rv", result_valid, 0);
    chk("reset_async_found", found, 0);
    chk("reset_async_rx", red_x, 0);
    chk("reset_async_ry", red_y, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    rv_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) rv_seen++;
    end
    chk("reset_no_result", rv_seen, 0);

    // Operation resumes after reset
    drive(1, 7, 9, 0, 64, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    wait_result("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
